// File: rtl/adc_interface.sv
// Memory-map to stream bridge for the ADC: turns PS register writes into
// channel-mux, SDC and buffer-config stream beats, and sinks timestamp beats.
module adc_interface #(
  parameter int MEM_SIZE             = 64,
  parameter int WD_DATA_WIDTH        = 32,
  parameter int CHAN_SAMPLES         = 8,
  parameter int SDC_SAMPLES          = 4,
  parameter int BUFF_CONFIG_WIDTH    = 2,
  parameter int BUFF_TIMESTAMP_WIDTH = 64,
  parameter int CHAN_MUX_BASE_ID     = 10,
  parameter int SDC_BASE_ID          = 20,
  parameter int BUFF_CONFIG_ID       = 30
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [MEM_SIZE-1:0]                   fresh_bits,
  input  logic [MEM_SIZE*WD_DATA_WIDTH-1:0]     read_resps,
  output logic                                  state_rdy,
  input  logic [BUFF_TIMESTAMP_WIDTH-1:0]       bufft_data,
  input  logic                                  bufft_valid,
  output logic                                  bufft_ready,
  output logic [BUFF_CONFIG_WIDTH-1:0]          buffc_data,
  output logic                                  buffc_valid,
  input  logic                                  buffc_ready,
  output logic [CHAN_SAMPLES*WD_DATA_WIDTH-1:0] cmc_data,
  output logic                                  cmc_valid,
  input  logic                                  cmc_ready,
  output logic [SDC_SAMPLES*WD_DATA_WIDTH-1:0]  sdc_data,
  output logic                                  sdc_valid,
  input  logic                                  sdc_ready
);

  localparam int CHANNEL_MUX_WIDTH = CHAN_SAMPLES * WD_DATA_WIDTH;
  localparam int SDC_DATA_WIDTH    = SDC_SAMPLES * WD_DATA_WIDTH;
  localparam int CMC_COMMIT_ID     = CHAN_MUX_BASE_ID + CHAN_SAMPLES;
  localparam int SDC_COMMIT_ID     = SDC_BASE_ID + SDC_SAMPLES;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] cmc_state;
  logic [0:0] sdc_state;
  logic [0:0] buffc_state;

  logic cmc_trigger;
  logic sdc_trigger;
  logic buffc_trigger;

  // Only the commit address fires a channel; payload writes just update read_resps.
  assign cmc_trigger   = fresh_bits[CMC_COMMIT_ID];
  assign sdc_trigger   = fresh_bits[SDC_COMMIT_ID];
  assign buffc_trigger = fresh_bits[BUFF_CONFIG_ID];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_rdy <= 1'b0;
    end else begin
      state_rdy <= 1'b1;
    end
  end

  assign bufft_ready = state_rdy;

  // A new trigger wins over a handshake in the same cycle so fresh data is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmc_state <= IDLE;
      cmc_data  <= '0;
    end else if (cmc_trigger) begin
      cmc_state <= HOLD;
      cmc_data  <= read_resps[CHAN_MUX_BASE_ID*WD_DATA_WIDTH +: CHANNEL_MUX_WIDTH];
    end else if (cmc_state == HOLD && cmc_ready) begin
      cmc_state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdc_state <= IDLE;
      sdc_data  <= '0;
    end else if (sdc_trigger) begin
      sdc_state <= HOLD;
      sdc_data  <= read_resps[SDC_BASE_ID*WD_DATA_WIDTH +: SDC_DATA_WIDTH];
    end else if (sdc_state == HOLD && sdc_ready) begin
      sdc_state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffc_state <= IDLE;
      buffc_data  <= '0;
    end else if (buffc_trigger) begin
      buffc_state <= HOLD;
      buffc_data  <= read_resps[BUFF_CONFIG_ID*WD_DATA_WIDTH +: BUFF_CONFIG_WIDTH];
    end else if (buffc_state == HOLD && buffc_ready) begin
      buffc_state <= IDLE;
    end
  end

  assign cmc_valid   = (cmc_state == HOLD);
  assign sdc_valid   = (sdc_state == HOLD);
  assign buffc_valid = (buffc_state == HOLD);

  // Timestamp beats are accepted and dropped; most map words are never looked at here.
  logic unused_inputs;
  assign unused_inputs = ^{bufft_data, bufft_valid, fresh_bits, read_resps};

endmodule

// File: tb/tb_adc_interface.sv
// Directed bench for adc_interface: loads map words, commits, and checks the
// three output streams against hand-computed values.
module tb_adc_interface;

  localparam int MEM_SIZE = 64;
  localparam int WD       = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [MEM_SIZE-1:0]   fresh_bits;
  logic [MEM_SIZE*WD-1:0] read_resps;
  logic                  state_rdy;
  logic [63:0]           bufft_data;
  logic                  bufft_valid;
  logic                  bufft_ready;
  logic [1:0]            buffc_data;
  logic                  buffc_valid;
  logic                  buffc_ready;
  logic [255:0]          cmc_data;
  logic                  cmc_valid;
  logic                  cmc_ready;
  logic [127:0]          sdc_data;
  logic                  sdc_valid;
  logic                  sdc_ready;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  adc_interface dut (
    .clk         (clk),
    .rst         (rst),
    .fresh_bits  (fresh_bits),
    .read_resps  (read_resps),
    .state_rdy   (state_rdy),
    .bufft_data  (bufft_data),
    .bufft_valid (bufft_valid),
    .bufft_ready (bufft_ready),
    .buffc_data  (buffc_data),
    .buffc_valid (buffc_valid),
    .buffc_ready (buffc_ready),
    .cmc_data    (cmc_data),
    .cmc_valid   (cmc_valid),
    .cmc_ready   (cmc_ready),
    .sdc_data    (sdc_data),
    .sdc_valid   (sdc_valid),
    .sdc_ready   (sdc_ready)
  );

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  // Inputs set before this call are seen at exactly one rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    fresh_bits  = '0;
    cmc_ready   = 1'b0;
    sdc_ready   = 1'b0;
    buffc_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic put_word(input int addr, input logic [31:0] v);
    read_resps[addr*WD +: WD] = v;
    fresh_bits[addr] = 1'b1;
  endtask

  task automatic load_cmc(input logic [31:0] v);
    for (int i = 0; i < 8; i++) put_word(10 + i, v);
    fresh_bits[18] = 1'b1;
  endtask

  task automatic load_sdc(input logic [31:0] v);
    for (int i = 0; i < 4; i++) put_word(20 + i, v);
    fresh_bits[24] = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    fresh_bits  = '0;
    read_resps  = '0;
    bufft_data  = '0;
    bufft_valid = 1'b0;
    cmc_ready   = 1'b0;
    sdc_ready   = 1'b0;
    buffc_ready = 1'b0;

    #12;
    checkOutput("rst_state_rdy", state_rdy, 0);
    checkOutput("rst_bufft_ready", bufft_ready, 0);
    checkOutput("rst_cmc_valid", cmc_valid, 0);
    checkOutput("rst_sdc_valid", sdc_valid, 0);
    checkOutput("rst_buffc_valid", buffc_valid, 0);
    checkOutput("rst_cmc_data", cmc_data, 0);
    checkOutput("rst_sdc_data", sdc_data, 0);
    checkOutput("rst_buffc_data", buffc_data, 0);

    @(negedge clk);
    rst         = 1'b1;
    bufft_valid = 1'b1;
    bufft_data  = 64'h0123_4567_89AB_CDEF;
    applyStimulus();
    checkOutput("state_rdy_up", state_rdy, 1);
    checkOutput("bufft_ready_up", bufft_ready, 1);

    // Channel mux: all payload plus commit in one cycle
    for (int i = 0; i < 8; i++) put_word(10 + i, 32'h11 + i);
    put_word(18, 32'hDEAD_BEEF);
    applyStimulus();
    checkOutput("cmc_valid_commit", cmc_valid, 1);
    checkOutput("cmc_data_commit", cmc_data,
      256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011);
    checkOutput("sdc_quiet", sdc_valid, 0);
    checkOutput("buffc_quiet", buffc_valid, 0);
    idle(50);
    checkOutput("cmc_valid_hold50", cmc_valid, 1);
    checkOutput("cmc_data_hold50", cmc_data,
      256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011);
    put_word(12, 32'h5555_5555);
    applyStimulus();
    checkOutput("cmc_payload_only", cmc_data,
      256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011);
    cmc_ready = 1'b1;
    applyStimulus();
    checkOutput("cmc_valid_hs", cmc_valid, 0);

    // SDC: payload spread over cycles, ready while idle must be ignored
    for (int i = 0; i < 4; i++) begin
      put_word(20 + i, 32'hA000_0001 + i);
      sdc_ready = 1'b1;
      applyStimulus();
      idle($urandom_range(0, 3));
      checkOutput("sdc_no_commit", sdc_valid, 0);
    end
    fresh_bits[24] = 1'b1;
    applyStimulus();
    checkOutput("sdc_valid_commit", sdc_valid, 1);
    checkOutput("sdc_data_commit", sdc_data,
      128'hA0000004_A0000003_A0000002_A0000001);
    checkOutput("cmc_idle_during_sdc", cmc_valid, 0);
    sdc_ready = 1'b1;
    applyStimulus();
    checkOutput("sdc_valid_hs", sdc_valid, 0);

    // Buffer config keeps only the low two bits
    put_word(30, 32'hFFFF_FFF6);
    applyStimulus();
    checkOutput("buffc_valid_commit", buffc_valid, 1);
    checkOutput("buffc_data_commit", buffc_data, 2'b10);
    buffc_ready = 1'b1;
    applyStimulus();
    checkOutput("buffc_valid_hs", buffc_valid, 0);

    // Relatch while holding, and trigger beating a coincident handshake
    load_cmc(32'h1234_5678);
    applyStimulus();
    checkOutput("cmc_data_a", cmc_data, {8{32'h1234_5678}});
    load_cmc(32'h9ABC_DEF0);
    applyStimulus();
    checkOutput("cmc_valid_relatch", cmc_valid, 1);
    checkOutput("cmc_data_relatch", cmc_data, {8{32'h9ABC_DEF0}});
    load_cmc(32'h0F0F_0F0F);
    cmc_ready = 1'b1;
    applyStimulus();
    checkOutput("cmc_valid_trig_hs", cmc_valid, 1);
    checkOutput("cmc_data_trig_hs", cmc_data, {8{32'h0F0F_0F0F}});
    cmc_ready = 1'b1;
    applyStimulus();
    checkOutput("cmc_valid_hs2", cmc_valid, 0);

    // Long hold on all three, then a joint handshake
    load_sdc(32'h2222_2222);
    put_word(30, 32'h0000_0001);
    load_cmc(32'h3333_3333);
    applyStimulus();
    idle(300);
    checkOutput("all_cmc_valid_300", cmc_valid, 1);
    checkOutput("all_sdc_valid_300", sdc_valid, 1);
    checkOutput("all_buffc_valid_300", buffc_valid, 1);
    checkOutput("all_cmc_data_300", cmc_data, {8{32'h3333_3333}});
    checkOutput("all_sdc_data_300", sdc_data, {4{32'h2222_2222}});
    checkOutput("all_buffc_data_300", buffc_data, 2'b01);
    cmc_ready   = 1'b1;
    sdc_ready   = 1'b1;
    buffc_ready = 1'b1;
    applyStimulus();
    checkOutput("all_cmc_valid_hs", cmc_valid, 0);
    checkOutput("all_sdc_valid_hs", sdc_valid, 0);
    checkOutput("all_buffc_valid_hs", buffc_valid, 0);

    // Staggered handshakes: only the addressed channel drops
    load_sdc(32'h4444_4444);
    put_word(30, 32'h0000_0003);
    load_cmc(32'h5555_5555);
    applyStimulus();
    cmc_ready = 1'b1;
    applyStimulus();
    checkOutput("stag1_cmc", cmc_valid, 0);
    checkOutput("stag1_sdc", sdc_valid, 1);
    checkOutput("stag1_buffc", buffc_valid, 1);
    idle(19);
    sdc_ready = 1'b1;
    applyStimulus();
    checkOutput("stag2_cmc", cmc_valid, 0);
    checkOutput("stag2_sdc", sdc_valid, 0);
    checkOutput("stag2_buffc", buffc_valid, 1);
    checkOutput("stag2_buffc_data", buffc_data, 2'b11);
    idle(19);
    buffc_ready = 1'b1;
    applyStimulus();
    checkOutput("stag3_buffc", buffc_valid, 0);

    // Asynchronous reset in the middle of a hold
    load_cmc(32'h6666_6666);
    applyStimulus();
    checkOutput("pre_rst_cmc_valid", cmc_valid, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_cmc_valid", cmc_valid, 0);
    checkOutput("async_state_rdy", state_rdy, 0);
    checkOutput("async_bufft_ready", bufft_ready, 0);
    checkOutput("async_cmc_data", cmc_data, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("release_no_edge", state_rdy, 0);
    applyStimulus();
    checkOutput("release_state_rdy", state_rdy, 1);
    checkOutput("release_cmc_valid", cmc_valid, 0);
    idle(5);
    checkOutput("release_cmc_stays", cmc_valid, 0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
